stream_mux_nto1: RTL and testbench
==================================

STREAM_MUX_NTO1 -- requirements
Module: stream_mux_nto1

Interface
REQ-001 The block SHALL have parameter N, default 4, number of input channels (legal 2..8).
REQ-002 The block SHALL have parameter W, default 8, data width in bits (legal 1..32).
REQ-003 The block SHALL use SW = clog2(N) as the select/channel-index width.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port mode  input  1  0 = SEL (external select), 1 = RR (round-robin).
REQ-007 The block SHALL have port sel  input  SW  channel index used in SEL mode.
REQ-008 The block SHALL have port in_valid  input  N  per-channel valid.
REQ-009 The block SHALL have port in_data  input  N*W  channel i occupies bits [i*W +: W].
REQ-010 The block SHALL have port in_ready  output  N  per-channel ready, combinational.
REQ-011 The block SHALL have port out_valid  output  1  output register holds data.
REQ-012 The block SHALL have port out_data  output  W  registered data.
REQ-013 The block SHALL have port out_chan  output  SW  source channel of out_data.
REQ-014 The block SHALL have port out_ready  input  1  downstream accepts.

Function
REQ-015 load_en SHALL equal (!out_valid || out_ready).
REQ-016 In SEL mode, grant SHALL be channel sel when sel < N and in_valid[sel]=1; otherwise there is no grant.
REQ-017 In RR mode, grant SHALL be the first channel with in_valid=1, searching ptr+1, ptr+2, ... modulo N, where ptr is the last RR-granted channel.
REQ-018 in_ready[i] SHALL be 1 only when load_en=1 and i is granted; at most one in_ready bit SHALL be high per cycle.
REQ-019 A transfer on channel i SHALL occur when in_valid[i] and in_ready[i] are both 1; on the next edge out_data=in_data[i], out_chan=i, out_valid=1 (latency 1 cycle).
REQ-020 When load_en=1 and there is no grant, out_valid SHALL go to 0 on the next edge; out_data and out_chan SHALL hold their values.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_chan and out_valid SHALL hold, and all in_ready bits SHALL be 0.
REQ-022 Simultaneous out_ready=1 and a new grant SHALL give back-to-back transfers, sustaining 1 word/cycle.
REQ-023 ptr SHALL update to the granted channel only on an RR-mode transfer; SEL-mode transfers SHALL leave ptr unchanged.
REQ-024 A mode or sel change SHALL take effect on the same-cycle grant evaluation and SHALL NOT alter a word already held in the output register.
REQ-025 An out-of-range sel (sel >= N) SHALL produce no grant and no X propagation.

Reset
REQ-026 With rst_n=0 at a clock edge: out_valid=0, out_data=0, out_chan=0, ptr=N-1, so the first RR grant searches from channel 0.
REQ-027 Reset asserted while a word is held SHALL discard that word; in_ready SHALL be all-0 while rst_n=0.

Structure
REQ-028 Package stream_mux_pkg SHALL hold the mode encodings MODE_SEL=1'b0 and MODE_RR=1'b1.
REQ-029 The RR priority search SHALL be a sub-module rr_arbiter (inputs req[N], ptr; outputs grant one-hot and grant index).
REQ-030 The top level SHALL contain only the output register, ptr, the mode/sel grant mux and the handshake logic.

Verification (N=4, W=8)
REQ-031 SEL mode, sel=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=A5, out_chan=2; in_ready=4'b0100 in the transfer cycle.
REQ-032 RR mode, all in_valid=1, out_ready=1, from reset -> out_chan sequence 0,1,2,3,0 on consecutive cycles with out_valid continuously 1.
REQ-033 Backpressure: word 8'h3C held, out_ready=0 for 5 cycles -> out_data=3C stable, in_ready=0000 throughout; out_ready=1 -> next queued word appears the following cycle.
REQ-034 RR mode, in_valid=4'b1010, ptr=1 -> grant ch3, then ch1, then ch3; channels 0 and 2 are never granted.
REQ-035 SEL mode, sel=2 with in_valid[2]=0 and other channels valid -> no grant, out_valid drops to 0 after draining.
REQ-036 rst_n=0 for one edge while out_valid=1 -> out_valid=0, out_data=00; the next RR grant is channel 0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// ---------------------------------------------------------------------------
// stream_mux_pkg
//   Shared definitions for the N-to-1 stream multiplexer.
//   - mode_e : arbitration mode (external select or round-robin)
// ---------------------------------------------------------------------------
package stream_mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,  // channel chosen by the external sel input
    MODE_RR  = 1'b1   // channel chosen by round-robin search
  } mode_e;

  localparam int N_MIN = 2;
  localparam int N_MAX = 8;
  localparam int W_MIN = 1;
  localparam int W_MAX = 32;

endpackage : stream_mux_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin priority search. Starting just after the last
//   granted channel (ptr), picks the first requesting channel, wrapping
//   modulo N.
//
// Ports
//   req       in  [N-1:0]   per-channel request
//   ptr       in  [SW-1:0]  last granted channel (0..N-1)
//   grant     out [N-1:0]   one-hot grant, all-zero when nothing requests
//   grant_idx out [SW-1:0]  index of the granted channel (0 when no grant)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx
);

  logic          found;
  logic [SW-1:0] idx;

  // NOTE: every variable driven here gets a default before the loop; a path
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    // Offsets 1..N visit ptr+1 first and ptr itself last.
    for (int k = 1; k <= N; k++) begin
      idx = SW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/stream_mux_nto1.sv
// ---------------------------------------------------------------------------
// stream_mux_nto1
//   N-to-1 valid/ready stream multiplexer with a single registered output
//   stage. Channel choice is either an external index (SEL mode) or a
//   round-robin search (RR mode). Sustains one word per cycle when the
//   downstream is ready.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   mode       in   0 = SEL, 1 = RR (see stream_mux_pkg::mode_e)
//   sel        in   [SW-1:0]  channel index used in SEL mode
//   in_valid   in   [N-1:0]   per-channel valid
//   in_data    in   [N*W-1:0] channel i at bits [i*W +: W]
//   in_ready   out  [N-1:0]   per-channel ready (combinational, one-hot or 0)
//   out_valid  out  output register holds a word
//   out_data   out  [W-1:0]   registered word
//   out_chan   out  [SW-1:0]  source channel of out_data
//   out_ready  in   downstream accepts
// ---------------------------------------------------------------------------
module stream_mux_nto1
  import stream_mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  input  logic           out_ready
);

  mode_e         cur_mode;
  logic          load_en;
  logic [SW-1:0] ptr;

  logic [N-1:0]  rr_grant;
  logic [SW-1:0] rr_idx;
  logic [N-1:0]  sel_grant;
  logic [SW-1:0] sel_idx;

  logic [N-1:0]  grant;
  logic [SW-1:0] grant_idx;
  logic          grant_any;
  logic [W-1:0]  grant_data;

  assign cur_mode = mode_e'(mode);

  // Output register can take a word when empty or being drained this cycle.
  assign load_en = !out_valid || out_ready;

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  // SEL-mode grant. Comparing sel against each legal index (rather than
  // indexing in_valid[sel]) keeps an out-of-range sel from reading past the
  // vector and yields a clean "no grant".
  always_comb begin
    sel_grant = '0;
    sel_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i) && in_valid[i]) begin
        sel_grant[i] = 1'b1;
        sel_idx      = SW'(i);
      end
    end
  end

  assign grant     = (cur_mode == MODE_RR) ? rr_grant : sel_grant;
  assign grant_idx = (cur_mode == MODE_RR) ? rr_idx   : sel_idx;
  assign grant_any = |grant;

  // in_ready is forced low during reset so nothing is consumed upstream
  // while the output register is being cleared.
  assign in_ready = (rst_n && load_en) ? grant : '0;

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SW'(i)) begin
        grant_data = in_data[i*W +: W];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      // Seeding ptr with the last channel makes the first RR search start at 0.
      ptr       <= SW'(N - 1);
    end else if (load_en) begin
      if (grant_any) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_chan  <= grant_idx;
        if (cur_mode == MODE_RR) begin
          ptr <= grant_idx;
        end
      end else begin
        // Drained with nothing to replace it: data/chan keep their last value.
        out_valid <= 1'b0;
      end
    end
  end

endmodule : stream_mux_nto1

// File: tb/tb_stream_mux_nto1.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_nto1
//   Self-checking bench for stream_mux_nto1 (N=4, W=8). A behavioural model
//   tracks the expected output register and round-robin pointer; directed
//   scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_stream_mux_nto1;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk;
  logic           rst_n;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_ready;

  stream_mux_nto1 #(
    .N (N),
    .W (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  int           m_chan  = 0;
  int           m_ptr   = N - 1;

  logic [N-1:0] last_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant according to the mode rules; -1 means no grant.
  function automatic int model_grant();
    if (mode == 1'b0) begin
      if (int'(sel) < N && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_ch(input int ch, input logic [W-1:0] d);
    in_data[ch*W +: W] = d;
  endtask

  // One clock: check in_ready before the edge, advance the model at the
  // edge, check the output register just after it.
  task automatic cycle(input string tag);
    int           g;
    logic         ld;
    logic [N-1:0] exp_rdy;
    #1;
    g       = model_grant();
    ld      = !m_valid || out_ready;
    exp_rdy = '0;
    if (rst_n && ld && g >= 0) exp_rdy[g] = 1'b1;
    last_rdy = in_ready;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_chan  = 0;
      m_ptr   = N - 1;
    end else if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*W +: W];
        m_chan  = g;
        if (mode == 1'b1) m_ptr = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".out_data"},  32'(out_data),  32'(m_data));
    check({tag, ".out_chan"},  32'(out_chan),  32'(m_chan));
  endtask

  initial begin
    int seq_a[5];
    int seq_b[3];
    seq_a = '{0, 1, 2, 3, 0};
    seq_b = '{3, 1, 3};

    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    cycle("rst0");
    cycle("rst1");
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_data",  32'(out_data),  32'd0);

    // SEL mode single transfer from channel 2
    rst_n     = 1'b1;
    mode      = 1'b0;
    sel       = 2'd2;
    in_valid  = 4'b0100;
    set_ch(2, 8'hA5);
    out_ready = 1'b1;
    cycle("sel_a5");
    check("sel_a5.rdy_xfer", 32'(last_rdy),  32'b0100);
    check("sel_a5.valid",    32'(out_valid), 32'd1);
    check("sel_a5.data",     32'(out_data),  32'hA5);
    check("sel_a5.chan",     32'(out_chan),  32'd2);
    in_valid = '0;
    cycle("sel_drain");

    // RR from reset, all channels valid: 0,1,2,3,0 back-to-back
    rst_n = 1'b0;
    cycle("rr_rst");
    rst_n    = 1'b1;
    mode     = 1'b1;
    in_valid = 4'hF;
    for (int i = 0; i < N; i++) set_ch(i, 8'(8'h10 + i));
    for (int k = 0; k < 5; k++) begin
      cycle("rr_seq");
      check("rr_seq.chan",  32'(out_chan),  32'(seq_a[k]));
      check("rr_seq.valid", 32'(out_valid), 32'd1);
    end

    // Backpressure: hold 3C for 5 cycles, then next word follows
    mode      = 1'b0;
    sel       = 2'd1;
    in_valid  = 4'b0010;
    set_ch(1, 8'h3C);
    out_ready = 1'b1;
    cycle("bp_load");
    check("bp_load.data", 32'(out_data), 32'h3C);
    set_ch(1, 8'h5A);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle("bp_hold");
      check("bp_hold.data", 32'(out_data), 32'h3C);
      check("bp_hold.rdy",  32'(last_rdy), 32'd0);
    end
    out_ready = 1'b1;
    cycle("bp_release");
    check("bp_release.data", 32'(out_data), 32'h5A);

    // RR with in_valid=1010 starting from ptr=1: 3,1,3
    rst_n = 1'b0;
    cycle("rr2_rst");
    rst_n    = 1'b1;
    mode     = 1'b1;
    in_valid = 4'b0010;
    cycle("rr2_ptr1");
    check("rr2_ptr1.chan", 32'(out_chan), 32'd1);
    in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      cycle("rr2_seq");
      check("rr2_seq.chan", 32'(out_chan), 32'(seq_b[k]));
    end

    // SEL on an idle channel: no grant, output drains
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b1011;
    cycle("sel_idle");
    check("sel_idle.valid", 32'(out_valid), 32'd0);
    check("sel_idle.rdy",   32'(last_rdy),  32'd0);

    // Reset while a word is held
    sel      = 2'd0;
    in_valid = 4'b0001;
    set_ch(0, 8'h99);
    cycle("rst_hold_load");
    check("rst_hold_load.valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    rst_n     = 1'b0;
    cycle("rst_hold");
    check("rst_hold.valid", 32'(out_valid), 32'd0);
    check("rst_hold.data",  32'(out_data),  32'd0);
    rst_n     = 1'b1;
    mode      = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    cycle("rst_hold_rr");
    check("rst_hold_rr.chan", 32'(out_chan), 32'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      mode      = 1'($urandom);
      sel       = SW'($urandom);
      in_valid  = N'($urandom);
      in_data   = (N*W)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_stream_mux_nto1
